fiber_dram_bridge: RTL and testbench
====================================

FIBER_DRAM_BRIDGE -- requirements
Module: fiber_dram_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, fill/writeback word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, read response limit; used only with FIBER_DRAM_TIMEOUT_EN.
REQ-004 SHALL have i_clk, input, 1, sole clock; all logic on the rising edge.
REQ-005 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have i_bank_addr, input, ADDR_WIDTH, bank DRAM address for a fill or writeback.
REQ-007 SHALL have i_fill_ready, input, 1, bank awaiting fill data; also acts as the fill request.
REQ-008 SHALL have o_fill_data, output, DATA_WIDTH, fill word to the bank.
REQ-009 SHALL have o_fill_valid, output, 1, fill word valid.
REQ-010 SHALL have i_wb_data, input, DATA_WIDTH, writeback word from the bank.
REQ-011 SHALL have i_wb_valid, input, 1, writeback word valid.
REQ-012 SHALL have o_wb_ready, output, 1, writeback accepted.
REQ-013 SHALL have o_mem_req_valid, output, 1, memory request valid.
REQ-014 SHALL have i_mem_req_ready, input, 1, memory accepts request.
REQ-015 SHALL have o_mem_req_we, output, 1, 1 = write, 0 = read.
REQ-016 SHALL have o_mem_req_addr, output, ADDR_WIDTH, request address.
REQ-017 SHALL have o_mem_req_wdata, output, DATA_WIDTH, write data.
REQ-018 SHALL have i_mem_rsp_valid, input, 1, read response valid.
REQ-019 SHALL have i_mem_rsp_data, input, DATA_WIDTH, read response data.
REQ-020 SHALL have o_mem_rsp_ready, output, 1, response accepted.
REQ-021 SHALL have o_err, output, 1, one-cycle pulse on read timeout; tied to 0 without FIBER_DRAM_TIMEOUT_EN.

Function
REQ-022 SHALL implement FSM states IDLE, WB_REQ, RD_REQ, RD_WAIT and FILL, with one request outstanding at most.
REQ-023 In IDLE, i_wb_valid SHALL take priority over i_fill_ready, so a read after a same-address writeback returns the new data.
REQ-024 In IDLE with i_wb_valid, the block SHALL pulse o_wb_ready for one cycle, latch i_bank_addr and i_wb_data, and go to WB_REQ.
REQ-025 In IDLE with i_fill_ready and no i_wb_valid, the block SHALL latch i_bank_addr and go to RD_REQ.
REQ-026 In WB_REQ and RD_REQ, o_mem_req_valid SHALL be 1 with addr, we and wdata held stable from registers until i_mem_req_ready.
REQ-027 After the accepting cycle, WB_REQ SHALL go to IDLE and RD_REQ SHALL go to RD_WAIT.
REQ-028 o_mem_rsp_ready SHALL be 1 in RD_WAIT and IDLE.
REQ-029 A response in IDLE SHALL be consumed and discarded (stale after reset); a response in RD_WAIT SHALL be latched and move the FSM to FILL.
REQ-030 In FILL, o_fill_valid SHALL be 1 with o_fill_data held until i_fill_ready, then the FSM SHALL return to IDLE.
REQ-031 Minimum fill latency SHALL be 3 cycles from fill request to o_fill_valid with zero memory wait.
REQ-032 In WB_REQ, RD_REQ, RD_WAIT and FILL, o_wb_ready SHALL be 0.
REQ-033 The fill transfer SHALL complete in one cycle when i_fill_ready and o_fill_valid are high together.

Reset
REQ-034 Reset SHALL force IDLE and clear the latched address/data, the timeout counter and all outputs, and SHALL drop any in-flight request.
REQ-035 Reset-time outputs SHALL be o_fill_valid=0, o_fill_data=0, o_wb_ready=0, o_mem_req_valid=0, o_mem_req_we=0, o_mem_req_addr=0, o_mem_req_wdata=0, o_mem_rsp_ready=0 and o_err=0.

Configuration
REQ-036 With FIBER_DRAM_TIMEOUT_EN defined, a counter SHALL run in RD_WAIT.
REQ-037 When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse o_err, load o_fill_data with all ones and go to FILL; a later response lands in IDLE and is discarded.
REQ-038 Without FIBER_DRAM_TIMEOUT_EN, no counter SHALL exist, RD_WAIT SHALL wait indefinitely, and o_err SHALL be 0.

Structure
REQ-039 The FSM state enum, the request-type encoding (read/write) and the all-ones error word width SHALL be defined in package fiber_pkg.
REQ-040 The block SHALL have no sub-module; the optional timeout counter stays inline.

Verification
REQ-041 A fill from addr 0x00000000FFFFFFFF with mem ready=1 and a 1-cycle response 0x1234 SHALL produce o_mem_req_addr=0x00000000FFFFFFFF, we=0, and o_fill_data=0x1234 valid on cycle 3.
REQ-042 i_wb_valid and i_fill_ready in the same cycle, addr 0x40, wb 0xBEEF, SHALL issue the write 0x40/0xBEEF first, then the read 0x40.
REQ-043 i_mem_req_ready low for 4 cycles SHALL hold o_mem_req_valid high with stable addr and data, with exactly one request accepted.
REQ-044 i_fill_ready dropped for 2 cycles in FILL SHALL hold o_fill_data stable, and the transfer SHALL complete when ready returns.
REQ-045 Reset asserted in RD_WAIT, then a response 0x5555 arriving, SHALL be discarded in IDLE with no o_fill_valid.
REQ-046 With FIBER_DRAM_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no response, o_err SHALL pulse once and o_fill_data SHALL be 0xFFFF valid.

Source files
------------

// File: rtl/fiber_pkg.sv
// fiber_pkg: shared types and constants for fiber_dram_bridge.
//   fiber_state_e : bridge FSM states
//   fiber_req_e   : memory request type (read / write)
//   ErrWordWidth / ErrWord : all-ones word loaded as fill data on a read timeout
package fiber_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWbReq,
      StRdReq,
      StRdWait,
      StFill
   } fiber_state_e;

   typedef enum logic {
      ReqRead  = 1'b0,
      ReqWrite = 1'b1
   } fiber_req_e;

   localparam int unsigned ErrWordWidth = 16;
   localparam logic [ErrWordWidth-1:0] ErrWord = '1;

endpackage

// File: rtl/fiber_dram_bridge.sv
// fiber_dram_bridge: moves fill (read) and writeback (write) words between a cache bank and a
// single-outstanding DRAM request/response port.
//
// Ports
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_bank_addr              : bank DRAM address for a fill or writeback
//   i_fill_ready             : bank wants fill data (also the fill request)
//   o_fill_data/o_fill_valid : fill word to the bank
//   i_wb_data/i_wb_valid     : writeback word from the bank
//   o_wb_ready               : writeback accepted (one-cycle pulse in idle)
//   o_mem_req_*              : memory request (valid/ready, we, addr, wdata)
//   i_mem_rsp_*/o_mem_rsp_ready : memory read response
//   o_err                    : one-cycle pulse on read timeout
//
// Optional feature: define FIBER_DRAM_TIMEOUT_EN to bound the read wait to TIMEOUT_CYCLES;
// on expiry the bank receives an all-ones fill word and o_err pulses. Without it o_err is 0.
module fiber_dram_bridge
   import fiber_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_bank_addr,
   input  logic                  i_fill_ready,
   output logic [DATA_WIDTH-1:0] o_fill_data,
   output logic                  o_fill_valid,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   input  logic                  i_wb_valid,
   output logic                  o_wb_ready,
   output logic                  o_mem_req_valid,
   input  logic                  i_mem_req_ready,
   output logic                  o_mem_req_we,
   output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
   output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
   input  logic                  i_mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
   output logic                  o_mem_rsp_ready,
   output logic                  o_err
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   fiber_state_e          state_q, state_d;
   fiber_req_e            we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
   logic                  wb_ready;
   logic                  run;

`ifdef FIBER_DRAM_TIMEOUT_EN
   localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned ErrReps = (DATA_WIDTH + ErrWordWidth - 1) / ErrWordWidth;
   localparam logic [DATA_WIDTH-1:0] ErrFill = DATA_WIDTH'({ErrReps{ErrWord}});

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      fill_data_d = fill_data_q;
      wb_ready    = 1'b0;
`ifdef FIBER_DRAM_TIMEOUT_EN
      cnt_d       = '0;
      err_d       = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            // Writeback first so a following same-address fill reads the new data.
            if (i_wb_valid) begin
               wb_ready = 1'b1;
               addr_d   = i_bank_addr;
               wdata_d  = i_wb_data;
               we_d     = ReqWrite;
               state_d  = StWbReq;
            end else if (i_fill_ready) begin
               addr_d  = i_bank_addr;
               we_d    = ReqRead;
               state_d = StRdReq;
            end
         end
         StWbReq: if (i_mem_req_ready) state_d = StIdle;
         StRdReq: if (i_mem_req_ready) state_d = StRdWait;
         StRdWait: begin
            if (i_mem_rsp_valid) begin
               fill_data_d = i_mem_rsp_data;
               state_d     = StFill;
            end
`ifdef FIBER_DRAM_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               fill_data_d = ErrFill;
               err_d       = 1'b1;
               state_d     = StFill;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StFill: if (i_fill_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= StIdle;
         we_q        <= ReqRead;
         addr_q      <= '0;
         wdata_q     <= '0;
         fill_data_q <= '0;
`ifdef FIBER_DRAM_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         fill_data_q <= fill_data_d;
`ifdef FIBER_DRAM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   // All outputs read as zero while reset is held, whatever state the FSM was in.
   assign run             = ~i_reset;
   assign o_wb_ready      = run & wb_ready;
   assign o_fill_valid    = run & (state_q == StFill);
   assign o_fill_data     = run ? fill_data_q : '0;
   assign o_mem_req_valid = run & ((state_q == StWbReq) | (state_q == StRdReq));
   assign o_mem_req_we    = run & (we_q == ReqWrite);
   assign o_mem_req_addr  = run ? addr_q : '0;
   assign o_mem_req_wdata = run ? wdata_q : '0;
   assign o_mem_rsp_ready = run & ((state_q == StIdle) | (state_q == StRdWait));
`ifdef FIBER_DRAM_TIMEOUT_EN
   assign o_err           = run & err_q;
`else
   assign o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_fiber_dram_bridge.sv
// Self-checking bench for fiber_dram_bridge: directed cycle table, hand-written corner
// sequences, then random writeback/fill traffic against a transaction-level memory model.
module tb_fiber_dram_bridge;

`ifdef FIBER_DRAM_TIMEOUT_EN
   localparam int unsigned ToCycles = 8;
`else
   localparam int unsigned ToCycles = 255;
`endif

   localparam logic [63:0] AZ = 64'h0;
   localparam logic [63:0] AF = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] A40 = 64'h40;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [63:0] i_bank_addr = '0;
   logic        i_fill_ready = 1'b0;
   logic [15:0] i_wb_data = '0;
   logic        i_wb_valid = 1'b0;
   logic        i_mem_req_ready;
   logic        i_mem_rsp_valid;
   logic [15:0] i_mem_rsp_data;
   logic [15:0] o_fill_data;
   logic        o_fill_valid;
   logic        o_wb_ready;
   logic        o_mem_req_valid;
   logic        o_mem_req_we;
   logic [63:0] o_mem_req_addr;
   logic [15:0] o_mem_req_wdata;
   logic        o_mem_rsp_ready;
   logic        o_err;

   // Memory side is driven by hand in directed tests and by the responder in random mode.
   logic        mem_auto = 1'b0;
   logic        man_req_ready = 1'b0, man_rsp_valid = 1'b0;
   logic [15:0] man_rsp_data = '0;
   logic        auto_req_ready = 1'b0, auto_rsp_valid = 1'b0;
   logic [15:0] auto_rsp_data = '0;
   assign i_mem_req_ready = mem_auto ? auto_req_ready : man_req_ready;
   assign i_mem_rsp_valid = mem_auto ? auto_rsp_valid : man_rsp_valid;
   assign i_mem_rsp_data  = mem_auto ? auto_rsp_data : man_rsp_data;

   int n_checks = 0;
   int n_pass = 0;

   always #5 i_clk = ~i_clk;

   fiber_dram_bridge #(
      .DATA_WIDTH    (16),
      .ADDR_WIDTH    (64),
      .TIMEOUT_CYCLES(ToCycles)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_bank_addr    (i_bank_addr),
      .i_fill_ready   (i_fill_ready),
      .o_fill_data    (o_fill_data),
      .o_fill_valid   (o_fill_valid),
      .i_wb_data      (i_wb_data),
      .i_wb_valid     (i_wb_valid),
      .o_wb_ready     (o_wb_ready),
      .o_mem_req_valid(o_mem_req_valid),
      .i_mem_req_ready(i_mem_req_ready),
      .o_mem_req_we   (o_mem_req_we),
      .o_mem_req_addr (o_mem_req_addr),
      .o_mem_req_wdata(o_mem_req_wdata),
      .i_mem_rsp_valid(i_mem_rsp_valid),
      .i_mem_rsp_data (i_mem_rsp_data),
      .o_mem_rsp_ready(o_mem_rsp_ready),
      .o_err          (o_err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
   endtask

   // Output snapshot; data fields count only when their qualifier is set.
   function automatic logic [127:0] pk(input logic fv, input logic [15:0] fd, input logic wr,
                                       input logic rv, input logic we, input logic [63:0] a,
                                       input logic [15:0] wd, input logic rr, input logic er);
      return 128'({fv, fv ? fd : 16'h0, wr, rv, rv ? we : 1'b0, rv ? a : 64'h0,
                   (rv && we) ? wd : 16'h0, rr, er});
   endfunction

   function automatic logic [127:0] dut_out();
      return pk(o_fill_valid, o_fill_data, o_wb_ready, o_mem_req_valid, o_mem_req_we,
                o_mem_req_addr, o_mem_req_wdata, o_mem_rsp_ready, o_err);
   endfunction

   function automatic logic [127:0] raw_out();
      return 128'({o_fill_valid, o_fill_data, o_wb_ready, o_mem_req_valid, o_mem_req_we,
                   o_mem_req_addr, o_mem_req_wdata, o_mem_rsp_ready, o_err});
   endfunction

   // f = {fill_valid, wb_ready, req_valid, req_we, rsp_ready, err}
   function automatic logic [127:0] ex(input logic [5:0] f, input logic [15:0] fd,
                                       input logic [63:0] a, input logic [15:0] wd);
      return pk(f[5], fd, f[4], f[3], f[2], a, wd, f[1], f[0]);
   endfunction

   typedef struct {
      logic        wbv;
      logic        frd;
      logic        rq;
      logic        rsv;
      logic [63:0] a;
      logic [15:0] wbd;
      logic [15:0] rsd;
      logic [127:0] exp;
   } vec_t;

   // ctl = {wb_valid, fill_ready, mem_req_ready, mem_rsp_valid}
   function automatic vec_t mk(input logic [3:0] ctl, input logic [63:0] a,
                               input logic [15:0] wbd, input logic [15:0] rsd,
                               input logic [127:0] exp);
      vec_t v;
      v.wbv = ctl[3];
      v.frd = ctl[2];
      v.rq  = ctl[1];
      v.rsv = ctl[0];
      v.a   = a;
      v.wbd = wbd;
      v.rsd = rsd;
      v.exp = exp;
      return v;
   endfunction

   // Transaction-level memory: what DRAM holds (fed by observed bus writes) and what the
   // bank believes it wrote (fed by accepted writebacks).
   logic [15:0] mem_model [logic [63:0]];
   logic [15:0] ref_mem   [logic [63:0]];
   int          rsp_delay = -1;
   logic [15:0] rsp_word = '0;

   function automatic logic [15:0] init_val(input logic [63:0] a);
      return a[15:0] ^ a[47:32] ^ 16'hA5C3;
   endfunction

   initial begin : mem_responder
      forever begin
         @(posedge i_clk);
         #1;
         auto_rsp_valid = 1'b0;
         if (rsp_delay == 0) begin
            auto_rsp_valid = 1'b1;
            auto_rsp_data  = rsp_word;
         end
         if (rsp_delay >= 0) rsp_delay--;
         auto_req_ready = ($urandom_range(0, 3) != 0);
         @(negedge i_clk);
         if (mem_auto && o_mem_req_valid && i_mem_req_ready) begin
            if (o_mem_req_we) begin
               mem_model[o_mem_req_addr] = o_mem_req_wdata;
            end else begin
               chk("one_outstanding", 128'(rsp_delay >= 0), 128'(1'b0));
               rsp_word  = mem_model.exists(o_mem_req_addr) ? mem_model[o_mem_req_addr]
                                                            : init_val(o_mem_req_addr);
               rsp_delay = $urandom_range(0, 3);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t        vecs[15];
      logic [63:0] pool[8];
      logic [63:0] a;
      logic [15:0] d;
      logic [15:0] got_data;
      logic        got;
      logic        seen;
      int          cnt;
      int          accepts;
      int          err_cnt;

      vecs[0]  = mk(4'b0000, AZ, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[1]  = mk(4'b0110, AF, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[2]  = mk(4'b0110, AF, 16'h0, 16'h0, ex(6'b001000, 16'h0, AF, 16'h0));
      vecs[3]  = mk(4'b0111, AF, 16'h0, 16'h1234, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[4]  = mk(4'b0110, AF, 16'h0, 16'h0, ex(6'b100000, 16'h1234, AZ, 16'h0));
      vecs[5]  = mk(4'b0000, AZ, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[6]  = mk(4'b1110, A40, 16'hBEEF, 16'h0, ex(6'b010010, 16'h0, AZ, 16'h0));
      vecs[7]  = mk(4'b0110, A40, 16'h0, 16'h0, ex(6'b001100, 16'h0, A40, 16'hBEEF));
      vecs[8]  = mk(4'b0110, A40, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[9]  = mk(4'b0110, A40, 16'h0, 16'h0, ex(6'b001000, 16'h0, A40, 16'h0));
      vecs[10] = mk(4'b0111, A40, 16'h0, 16'hBEEF, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[11] = mk(4'b0110, A40, 16'h0, 16'h0, ex(6'b100000, 16'hBEEF, AZ, 16'h0));
      vecs[12] = mk(4'b0000, AZ, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[13] = mk(4'b0001, AZ, 16'h0, 16'h7777, ex(6'b000010, 16'h0, AZ, 16'h0));
      vecs[14] = mk(4'b0000, AZ, 16'h0, 16'h0, ex(6'b000010, 16'h0, AZ, 16'h0));

      pool[0] = AF;
      pool[1] = A40;
      pool[2] = 64'h1000;
      pool[3] = 64'hFFFF_FFFF_FFFF_FFF0;
      pool[4] = 64'h8000_0000_0000_0000;
      pool[5] = 64'h1234_5678_9ABC_DEF0;
      pool[6] = AZ;
      pool[7] = 64'h42;

      // Reset: everything low while held, then idle with response ready.
      tick();
      tick();
      smp();
      chk("reset_outputs", raw_out(), 128'h0);
      tick();
      i_reset = 1'b0;
      smp();
      chk("post_reset_idle", dut_out(), ex(6'b000010, 16'h0, AZ, 16'h0));

      // Directed cycle table: 3-cycle fill, writeback priority, stale response.
      for (int i = 0; i < 15; i++) begin
         tick();
         i_wb_valid    = vecs[i].wbv;
         i_fill_ready  = vecs[i].frd;
         i_bank_addr   = vecs[i].a;
         i_wb_data     = vecs[i].wbd;
         man_req_ready = vecs[i].rq;
         man_rsp_valid = vecs[i].rsv;
         man_rsp_data  = vecs[i].rsd;
         smp();
         chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
      end

      // Memory not ready for 4 cycles: request held stable, accepted exactly once.
      tick();
      i_wb_valid = 1'b1;
      i_bank_addr = 64'h1000;
      i_wb_data = 16'hCAFE;
      man_req_ready = 1'b0;
      man_rsp_valid = 1'b0;
      smp();
      chk("stall_wb_ready", 128'(o_wb_ready), 128'(1'b1));
      tick();
      i_wb_valid = 1'b0;
      i_bank_addr = AZ;
      i_wb_data = 16'h0;
      for (int k = 0; k < 4; k++) begin
         smp();
         chk($sformatf("stall_hold%0d", k),
             128'({o_mem_req_valid, o_mem_req_we, o_mem_req_addr, o_mem_req_wdata}),
             128'({1'b1, 1'b1, 64'h1000, 16'hCAFE}));
         tick();
      end
      man_req_ready = 1'b1;
      accepts = 0;
      for (int k = 0; k < 4; k++) begin
         smp();
         if (o_mem_req_valid && i_mem_req_ready) accepts++;
         tick();
      end
      chk("stall_single_accept", 128'(accepts), 128'(1));

      // Bank not ready for 2 FILL cycles: fill word held until ready returns.
      i_fill_ready = 1'b1;
      i_bank_addr = 64'h2000;
      smp();
      tick();
      smp();
      chk("fill_rd_req", 128'({o_mem_req_valid, o_mem_req_we, o_mem_req_addr}),
          128'({1'b1, 1'b0, 64'h2000}));
      tick();
      i_fill_ready = 1'b0;
      man_rsp_valid = 1'b1;
      man_rsp_data = 16'h0F0F;
      smp();
      tick();
      man_rsp_valid = 1'b0;
      man_rsp_data = 16'h0;
      smp();
      chk("fill_stall0", 128'({o_fill_valid, o_fill_data}), 128'({1'b1, 16'h0F0F}));
      tick();
      smp();
      chk("fill_stall1", 128'({o_fill_valid, o_fill_data}), 128'({1'b1, 16'h0F0F}));
      tick();
      i_fill_ready = 1'b1;
      smp();
      chk("fill_done", 128'({o_fill_valid, o_fill_data}), 128'({1'b1, 16'h0F0F}));
      tick();
      i_fill_ready = 1'b0;
      smp();
      chk("fill_released", 128'(o_fill_valid), 128'(1'b0));

      // Reset while waiting for a read: the late response is dropped in idle.
      tick();
      i_fill_ready = 1'b1;
      i_bank_addr = 64'h3000;
      man_req_ready = 1'b1;
      smp();
      tick();
      smp();
      tick();
      i_fill_ready = 1'b0;
      man_req_ready = 1'b0;
      smp();
      chk("rdwait_rsp_ready", 128'({o_mem_rsp_ready, o_mem_req_valid}), 128'({1'b1, 1'b0}));
      tick();
      i_reset = 1'b1;
      smp();
      chk("reset_mid_read", raw_out(), 128'h0);
      tick();
      i_reset = 1'b0;
      man_rsp_valid = 1'b1;
      man_rsp_data = 16'h5555;
      smp();
      chk("stale_rsp_ready", 128'(o_mem_rsp_ready), 128'(1'b1));
      tick();
      man_rsp_valid = 1'b0;
      man_rsp_data = 16'h0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         smp();
         if (o_fill_valid || o_mem_req_valid) seen = 1'b1;
         tick();
      end
      chk("stale_rsp_dropped", 128'(seen), 128'(1'b0));

`ifdef FIBER_DRAM_TIMEOUT_EN
      // No response: one error pulse and an all-ones fill word.
      i_fill_ready = 1'b1;
      i_bank_addr = 64'h4000;
      man_req_ready = 1'b1;
      smp();
      tick();
      i_fill_ready = 1'b0;
      smp();
      err_cnt = 0;
      seen = 1'b0;
      got_data = 16'h0;
      for (int k = 0; k < 40; k++) begin
         tick();
         smp();
         if (o_err) err_cnt++;
         if (o_fill_valid && !seen) begin
            seen = 1'b1;
            got_data = o_fill_data;
         end
      end
      tick();
      i_fill_ready = 1'b1;
      smp();
      tick();
      i_fill_ready = 1'b0;
      man_req_ready = 1'b0;
      chk("timeout_err_pulses", 128'(err_cnt), 128'(1));
      chk("timeout_fill_valid", 128'(seen), 128'(1'b1));
      chk("timeout_fill_data", 128'(got_data), 128'(16'hFFFF));
`else
      err_cnt = 0;
`endif

      // Random writebacks and fills against the memory model.
      mem_auto = 1'b1;
      for (int n = 0; n < 60; n++) begin
         a = pool[$urandom_range(0, 7)];
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
         tick();
         i_bank_addr = a;
         got = 1'b0;
         cnt = 0;
         if ($urandom_range(0, 2) == 0) begin
            d = 16'($urandom);
            i_wb_valid = 1'b1;
            i_wb_data = d;
            while (!got && cnt < 50) begin
               smp();
               if (o_wb_ready) got = 1'b1;
               else begin
                  cnt++;
                  tick();
               end
            end
            tick();
            i_wb_valid = 1'b0;
            chk($sformatf("rand%0d_wb_accepted", n), 128'(got), 128'(1'b1));
            if (got) ref_mem[a] = d;
         end else begin
            i_fill_ready = 1'b1;
            got_data = 16'h0;
            while (!got && cnt < 100) begin
               smp();
               if (o_fill_valid) begin
                  got = 1'b1;
                  got_data = o_fill_data;
               end else begin
                  cnt++;
                  tick();
               end
            end
            tick();
            i_fill_ready = 1'b0;
            chk($sformatf("rand%0d_fill_arrived", n), 128'(got), 128'(1'b1));
            chk($sformatf("rand%0d_fill_data a=%h", n, a), 128'(got_data),
                128'(ref_mem.exists(a) ? ref_mem[a] : init_val(a)));
         end
      end
      for (int k = 0; k < 10; k++) tick();
      if (err_cnt < 0) $display("unreachable");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
